alu_ctrl: RTL and testbench
===========================

# alu_ctrl

Sequencing front-end for the datapath ALU. Accepts ARM-style data-processing requests over a valid/ready handshake and translates the 4-bit ARM opcode into ALU select codes and operand routing, running one or two ALU passes. Captures the result and maintains the architectural status flags (V, N, Z, C). Sits between instruction decode/register read and the ALU/register-file write-back path.

## Interface
- WIDTH, 32, datapath and operand width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_op  in  4  ARM data-processing opcode.
- req_setflags  in  1  S bit; update flags on completion.
- req_a, req_b  in  WIDTH  operands (Rn, shifted operand).
- alu_s  out  4  ALU select code.
- alu_a, alu_b  out  WIDTH  ALU operands.
- alu_sign  out  1  constant 1 (signed compare semantics).
- alu_y  in  WIDTH  ALU result, combinational from alu_s/alu_a/alu_b.
- alu_flags  in  4  ALU flags: bit0 V, bit1 N, bit2 Z, bit3 C.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  WIDTH  final result.
- rsp_write  out  1  result targets Rd (0 for TST/CMP/CMN).
- rsp_illegal  out  1  opcode unsupported; result invalid.
- flags  out  4  registered status, same bit order as alu_flags.

## Operation
- Opcode map (ARM -> ALU select, operands): AND 0000 -> 0101; SUB 0010 -> 1011; RSB 0011 -> 1011 with A/B swapped; ADD 0100 -> 0001; TST 1000 -> 0101, no write; CMP 1010 -> 1011, no write; CMN 1011 -> 0001, no write; ORR 1100 -> 0110; MOV 1101 -> 0000; MVN 1111 -> 0111.
- BIC 1110: two passes. Pass 1 S=0111, alu_b=req_b, result stored in tmp. Pass 2 S=0101, alu_a=req_a, alu_b=tmp.
- EOR, ADC, SBC, RSC and TEQ are illegal: no ALU pass, rsp_illegal=1, rsp_write=0, flags unchanged.
- Operands and opcode are latched on accept and held stable on alu_* for the entire EXEC cycle.
- Flag update applies only when setflags=1, legal, at final EXEC:
  - Arithmetic ops (ADD/SUB/RSB/CMP/CMN) load all four bits from alu_flags.
  - Logical ops (AND/ORR/MOV/MVN/TST/BIC) load N, Z only and keep C, V.
- FSM states: IDLE, EXEC1, EXEC2, RESP.
  - IDLE -> EXEC1 on req_valid & req_ready, or IDLE -> RESP directly if illegal.
  - EXEC1 -> EXEC2 for BIC, else EXEC1 -> RESP.
  - EXEC2 -> RESP.
  - RESP -> IDLE on rsp_ready.
- Reset: state IDLE; flags, rsp_result, tmp, alu_s, alu_a and alu_b all 0; rsp_valid, rsp_write and rsp_illegal 0; req_ready 1 the cycle after reset deasserts.

## Timing
- Accept at edge T. Single-pass EXEC during T..T+1, result and flags captured at T+1, rsp_valid high from T+1.
- BIC: rsp_valid high from T+2. Illegal: rsp_valid high from T+1.
- rsp_* and flags are registered. rsp_* are held constant while rsp_valid & !rsp_ready.
- No new request is accepted until the RESP handshake completes; req_ready is 0 in the handshake cycle itself. Throughput is one request per 3 cycles (single-pass).
- Reset mid-operation aborts the operation: no response is produced, flags clear to 0, and the request is lost.
- Arithmetic: all results are WIDTH bits, wrap-around modulo 2^WIDTH. Carry and overflow come only from alu_flags.

## Structure
- Package alu_ctrl_pkg holds:
  - ARM opcode constants and ALU select constants (0000 pass-B through 1011 sub).
  - state enum.
  - flag bit indices (V=0, N=1, Z=2, C=3).
- Sub-module alu_op_decode, combinational. Maps req_op to {alu select(s), swap, two_pass, write, arith, illegal}.

## Test plan
- ADD A=5, B=7, S=1 -> rsp_result 12, rsp_write 1, flags N=0 Z=0, rsp_valid one cycle after accept.
- CMP A=3, B=3, S=1 -> rsp_write 0, Z=1. A following MOV with S=0 leaves flags unchanged.
- RSB A=10, B=3 -> alu_a=3 and alu_b=10 during EXEC, result 0xFFFFFFF9, N=1 with S=1.
- BIC A=0xFF, B=0x0F -> alu_s 0111 then 0101 on consecutive cycles, result 0x000000F0, rsp_valid two cycles after accept.
- EOR request -> rsp_illegal 1 one cycle after accept, no EXEC state, flags unchanged.
- Hold rsp_ready low 3 cycles -> rsp_* stable and req_ready 0. Separately, assert reset during BIC EXEC2 -> IDLE next cycle, rsp_valid 0, flags 0000.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared constants, types and helpers for alu_ctrl
// Purpose: ARM opcode and ALU select constants, FSM state type, flag bit
//          indices, decoded-operation struct and the flag merge helper.
// Ports:   none (package).
package alu_ctrl_pkg;

    // ARM data-processing opcodes
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // ALU select codes
    localparam logic [3:0] ALU_PASSB = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_NOTB  = 4'b0111;
    localparam logic [3:0] ALU_SUB   = 4'b1011;

    // Flag bit positions, shared by alu_flags and flags
    localparam int FLAG_V = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC1 = 2'd1,
        ST_EXEC2 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] sel1;      // select for the first (or only) pass
        logic [3:0] sel2;      // select for the second pass (BIC only)
        logic       swap;      // route Rn to alu_b and operand 2 to alu_a
        logic       two_pass;
        logic       write;     // result targets Rd
        logic       arith;     // C and V are meaningful
        logic       illegal;
    } decode_t;

    // Logical ops only refresh N and Z; C and V carry over from before.
    function automatic logic [3:0] merge_flags(input logic [3:0] cur,
                                               input logic [3:0] alu,
                                               input logic       arith);
        logic [3:0] nxt;
        nxt         = arith ? alu : cur;
        nxt[FLAG_N] = alu[FLAG_N];
        nxt[FLAG_Z] = alu[FLAG_Z];
        return nxt;
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// rtl/alu_ctrl_if.sv - request, ALU and response bus of alu_ctrl
// Purpose: groups the request handshake, the ALU drive/return signals and
//          the response handshake plus status flags.
// Ports:   slave  = alu_ctrl side; master = requester/ALU/consumer side.
interface alu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic             req_setflags;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic [3:0]       alu_s;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_sign;
    logic [WIDTH-1:0] alu_y;
    logic [3:0]       alu_flags;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_write;
    logic             rsp_illegal;
    logic [3:0]       flags;

    modport slave (
        input  req_valid, req_op, req_setflags, req_a, req_b,
        input  alu_y, alu_flags, rsp_ready,
        output req_ready, alu_s, alu_a, alu_b, alu_sign,
        output rsp_valid, rsp_result, rsp_write, rsp_illegal, flags
    );

    modport master (
        output req_valid, req_op, req_setflags, req_a, req_b,
        output alu_y, alu_flags, rsp_ready,
        input  req_ready, alu_s, alu_a, alu_b, alu_sign,
        input  rsp_valid, rsp_result, rsp_write, rsp_illegal, flags
    );
endinterface

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - ARM opcode to ALU control decode
// Purpose: combinational map from ARM data-processing opcode to ALU selects,
//          operand swap, pass count, write-back, arithmetic and illegal flags.
// Ports:   i_op  - ARM opcode
//          o_dec - decoded control (decode_t)
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] i_op,
    output decode_t    o_dec
);

    always_comb begin
        o_dec       = '0;
        o_dec.write = 1'b1;
        case (i_op)
            OP_AND: o_dec.sel1 = ALU_AND;
            OP_SUB: begin o_dec.sel1 = ALU_SUB; o_dec.arith = 1'b1; end
            OP_RSB: begin o_dec.sel1 = ALU_SUB; o_dec.arith = 1'b1; o_dec.swap = 1'b1; end
            OP_ADD: begin o_dec.sel1 = ALU_ADD; o_dec.arith = 1'b1; end
            OP_TST: begin o_dec.sel1 = ALU_AND; o_dec.write = 1'b0; end
            OP_CMP: begin o_dec.sel1 = ALU_SUB; o_dec.arith = 1'b1; o_dec.write = 1'b0; end
            OP_CMN: begin o_dec.sel1 = ALU_ADD; o_dec.arith = 1'b1; o_dec.write = 1'b0; end
            OP_ORR: o_dec.sel1 = ALU_OR;
            OP_MOV: o_dec.sel1 = ALU_PASSB;
            // BIC = Rn AND NOT op2: invert op2 first, then AND with Rn
            OP_BIC: begin o_dec.sel1 = ALU_NOTB; o_dec.sel2 = ALU_AND; o_dec.two_pass = 1'b1; end
            OP_MVN: o_dec.sel1 = ALU_NOTB;
            default: begin o_dec.illegal = 1'b1; o_dec.write = 1'b0; end
        endcase
    end

endmodule

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - ALU sequencing front-end with status flags
// Purpose: accepts ARM data-processing requests, drives one or two ALU
//          passes, captures the result and maintains V/N/Z/C.
// Ports:   clk   - rising-edge clock
//          reset - synchronous active-high reset
//          bus   - alu_ctrl_if.slave (request, ALU and response signals)
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic       clk,
    input  logic       reset,
    alu_ctrl_if.slave  bus
);

    decode_t          w_dec;

    state_t           r_state;
    logic             r_req_ready;
    logic [3:0]       r_alu_s;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;     // also holds the BIC intermediate (tmp)
    logic [3:0]       r_sel2;
    logic             r_two_pass;
    logic             r_write;
    logic             r_arith;
    logic             r_setflags;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_write;
    logic             r_rsp_illegal;
    logic [3:0]       r_flags;

    alu_op_decode u_decode (
        .i_op  (bus.req_op),
        .o_dec (w_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b1;
            r_alu_s       <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_sel2        <= '0;
            r_two_pass    <= 1'b0;
            r_write       <= 1'b0;
            r_arith       <= 1'b0;
            r_setflags    <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_write   <= 1'b0;
            r_rsp_illegal <= 1'b0;
            r_flags       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        if (w_dec.illegal) begin
                            // Response fields settle now; rsp_valid follows
                            // one cycle later so latency matches a single pass.
                            r_rsp_result  <= '0;
                            r_rsp_write   <= 1'b0;
                            r_rsp_illegal <= 1'b1;
                            r_state       <= ST_RESP;
                        end else begin
                            r_alu_s    <= w_dec.sel1;
                            r_alu_a    <= w_dec.swap ? bus.req_b : bus.req_a;
                            r_alu_b    <= w_dec.swap ? bus.req_a : bus.req_b;
                            r_sel2     <= w_dec.sel2;
                            r_two_pass <= w_dec.two_pass;
                            r_write    <= w_dec.write;
                            r_arith    <= w_dec.arith;
                            r_setflags <= bus.req_setflags;
                            r_state    <= ST_EXEC1;
                        end
                    end
                end
                ST_EXEC1, ST_EXEC2: begin
                    if (r_state == ST_EXEC1 && r_two_pass) begin
                        // alu_a keeps Rn; the first-pass result becomes alu_b
                        r_alu_s <= r_sel2;
                        r_alu_b <= bus.alu_y;
                        r_state <= ST_EXEC2;
                    end else begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_result  <= bus.alu_y;
                        r_rsp_write   <= r_write;
                        r_rsp_illegal <= 1'b0;
                        if (r_setflags) begin
                            r_flags <= merge_flags(r_flags, bus.alu_flags, r_arith);
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (!r_rsp_valid) begin
                        // only reached on the illegal path
                        r_rsp_valid <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.alu_s       = r_alu_s;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_sign    = 1'b1;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_result  = r_rsp_result;
    assign bus.rsp_write   = r_rsp_write;
    assign bus.rsp_illegal = r_rsp_illegal;
    assign bus.flags       = r_flags;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - self-checking testbench for alu_ctrl
module tb_alu_ctrl;
    import alu_ctrl_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        write;
        logic        ill;
        logic [1:0]  lat;
        logic [3:0]  flags;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_ctrl_if #(.WIDTH(32)) bus();

    alu_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    logic [3:0] m_flags = 4'b0000;

    // Behavioural ALU stub
    logic [32:0] s_t;
    logic [31:0] s_y;
    logic [3:0]  s_f;
    always_comb begin
        s_t = '0;
        s_y = '0;
        s_f = '0;
        case (bus.alu_s)
            ALU_PASSB: s_y = bus.alu_b;
            ALU_ADD: begin
                s_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                s_y = s_t[31:0];
                s_f[FLAG_C] = s_t[32];
                s_f[FLAG_V] = (bus.alu_a[31] == bus.alu_b[31]) && (s_y[31] != bus.alu_a[31]);
            end
            ALU_AND:  s_y = bus.alu_a & bus.alu_b;
            ALU_OR:   s_y = bus.alu_a | bus.alu_b;
            ALU_NOTB: s_y = ~bus.alu_b;
            ALU_SUB: begin
                s_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
                s_y = s_t[31:0];
                s_f[FLAG_C] = ~s_t[32];
                s_f[FLAG_V] = (bus.alu_a[31] != bus.alu_b[31]) && (s_y[31] != bus.alu_a[31]);
            end
            default: s_y = '0;
        endcase
        s_f[FLAG_N] = s_y[31];
        s_f[FLAG_Z] = (s_y == 32'd0);
    end
    assign bus.alu_y     = s_y;
    assign bus.alu_flags = s_f;

    // Reference model: ARM data-processing semantics
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input logic [3:0] f);
        exp_t e;
        longint sr;
        logic [63:0] u;
        logic arith, c;
        e = '0; e.write = 1'b1; e.lat = 2'd1; e.flags = f;
        sr = 0; u = '0; arith = 1'b0; c = 1'b0;
        case (op)
            OP_AND: e.res = a & b;
            OP_ORR: e.res = a | b;
            OP_MOV: e.res = b;
            OP_MVN: e.res = ~b;
            OP_TST: begin e.res = a & b; e.write = 1'b0; end
            OP_BIC: begin e.res = a & ~b; e.lat = 2'd2; end
            OP_ADD, OP_CMN: begin
                e.res = a + b; arith = 1'b1;
                sr = longint'($signed(a)) + longint'($signed(b));
                u = 64'(a) + 64'(b); c = u[32];
                if (op == OP_CMN) e.write = 1'b0;
            end
            OP_SUB, OP_CMP: begin
                e.res = a - b; arith = 1'b1;
                sr = longint'($signed(a)) - longint'($signed(b));
                c = (a >= b);
                if (op == OP_CMP) e.write = 1'b0;
            end
            OP_RSB: begin
                e.res = b - a; arith = 1'b1;
                sr = longint'($signed(b)) - longint'($signed(a));
                c = (b >= a);
            end
            default: begin e.ill = 1'b1; e.write = 1'b0; end
        endcase
        if (!e.ill && s) begin
            e.flags[FLAG_N] = e.res[31];
            e.flags[FLAG_Z] = (e.res == 32'd0);
            if (arith) begin
                e.flags[FLAG_C] = c;
                e.flags[FLAG_V] = (sr != longint'($signed(e.res)));
            end
        end
        return e;
    endfunction

    // Observations from the last request
    logic [31:0] g_res;
    logic        g_write, g_ill, g_timeout, g_stable, g_rdy_low, g_rdy_after;
    logic [3:0]  g_flags, g_pre_s;
    int          g_lat;
    logic [3:0]  g_s [0:1];
    logic [31:0] g_a [0:1];
    logic [31:0] g_b [0:1];

    task automatic run_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input int hold);
        int n;
        g_timeout = 1'b0; g_stable = 1'b1;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.req_ready) g_timeout = 1'b1;
        g_pre_s = bus.alu_s;
        bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_setflags = s;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        g_lat = 0;
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            if (g_lat < 2) begin
                g_s[g_lat] = bus.alu_s; g_a[g_lat] = bus.alu_a; g_b[g_lat] = bus.alu_b;
            end
            g_lat++;
            n++;
        end
        if (!bus.rsp_valid) g_timeout = 1'b1;
        g_res = bus.rsp_result; g_write = bus.rsp_write; g_ill = bus.rsp_illegal;
        g_flags = bus.flags;
        g_rdy_low = !bus.req_ready;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== g_res || bus.rsp_write !== g_write ||
                bus.rsp_illegal !== g_ill || bus.flags !== g_flags) g_stable = 1'b0;
            if (bus.req_ready !== 1'b0) g_rdy_low = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        g_rdy_after = bus.req_ready;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready);
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_write, bus.rsp_illegal, bus.flags, bus.alu_s} !== 11'd0) begin
            failures++;
            $display("FAIL reset_ctrl got valid=%b write=%b ill=%b flags=%b alu_s=%b exp all 0",
                     bus.rsp_valid, bus.rsp_write, bus.rsp_illegal, bus.flags, bus.alu_s);
        end
        checks++;
        if ({bus.rsp_result, bus.alu_a, bus.alu_b} !== 96'd0) begin
            failures++;
            $display("FAIL reset_data got res=%h a=%h b=%h exp 0", bus.rsp_result, bus.alu_a, bus.alu_b);
        end
        checks++;
        if (bus.alu_sign !== 1'b1) begin
            failures++; $display("FAIL alu_sign got=%b exp=1", bus.alu_sign);
        end
        m_flags = 4'b0000;
    endtask

    task automatic test_add;
        exp_t e;
        e = model(OP_ADD, 32'd5, 32'd7, 1'b1, m_flags);
        run_req(OP_ADD, 32'd5, 32'd7, 1'b1, 0);
        checks++;
        if (g_timeout || g_res !== 32'd12 || g_write !== 1'b1 || g_lat != 1) begin
            failures++;
            $display("FAIL add got res=%0d write=%b lat=%0d to=%b exp res=12 write=1 lat=1",
                     g_res, g_write, g_lat, g_timeout);
        end
        checks++;
        if (g_flags !== e.flags || g_flags[FLAG_N] !== 1'b0 || g_flags[FLAG_Z] !== 1'b0) begin
            failures++; $display("FAIL add_flags got=%b exp=%b", g_flags, e.flags);
        end
        m_flags = e.flags;
    endtask

    task automatic test_cmp_mov;
        exp_t e;
        e = model(OP_CMP, 32'd3, 32'd3, 1'b1, m_flags);
        run_req(OP_CMP, 32'd3, 32'd3, 1'b1, 0);
        checks++;
        if (g_write !== 1'b0 || g_flags[FLAG_Z] !== 1'b1 || g_flags !== e.flags) begin
            failures++;
            $display("FAIL cmp got write=%b flags=%b exp write=0 flags=%b", g_write, g_flags, e.flags);
        end
        m_flags = e.flags;
        run_req(OP_MOV, 32'd0, 32'h8000_0000, 1'b0, 0);
        checks++;
        if (g_res !== 32'h8000_0000 || g_flags !== m_flags) begin
            failures++;
            $display("FAIL mov_noflags got res=%h flags=%b exp res=80000000 flags=%b", g_res, g_flags, m_flags);
        end
    endtask

    task automatic test_rsb;
        exp_t e;
        e = model(OP_RSB, 32'd10, 32'd3, 1'b1, m_flags);
        run_req(OP_RSB, 32'd10, 32'd3, 1'b1, 0);
        checks++;
        if (g_s[0] !== ALU_SUB || g_a[0] !== 32'd3 || g_b[0] !== 32'd10) begin
            failures++;
            $display("FAIL rsb_swap got s=%b a=%0d b=%0d exp s=1011 a=3 b=10", g_s[0], g_a[0], g_b[0]);
        end
        checks++;
        if (g_res !== 32'hFFFF_FFF9 || g_flags[FLAG_N] !== 1'b1 || g_flags !== e.flags) begin
            failures++;
            $display("FAIL rsb got res=%h flags=%b exp res=fffffff9 flags=%b", g_res, g_flags, e.flags);
        end
        m_flags = e.flags;
    endtask

    task automatic test_bic;
        exp_t e;
        e = model(OP_BIC, 32'hFF, 32'h0F, 1'b1, m_flags);
        run_req(OP_BIC, 32'hFF, 32'h0F, 1'b1, 0);
        checks++;
        if (g_lat != 2 || g_s[0] !== ALU_NOTB || g_s[1] !== ALU_AND || g_b[0] !== 32'h0F ||
            g_a[1] !== 32'hFF || g_b[1] !== 32'hFFFF_FFF0) begin
            failures++;
            $display("FAIL bic_seq got lat=%0d s0=%b s1=%b b0=%h a1=%h b1=%h exp lat=2 s0=0111 s1=0101 b0=f a1=ff b1=fffffff0",
                     g_lat, g_s[0], g_s[1], g_b[0], g_a[1], g_b[1]);
        end
        checks++;
        if (g_res !== 32'h0000_00F0 || g_flags !== e.flags) begin
            failures++; $display("FAIL bic got res=%h flags=%b exp res=f0 flags=%b", g_res, g_flags, e.flags);
        end
        m_flags = e.flags;
    endtask

    task automatic test_illegal;
        run_req(OP_EOR, 32'h1234, 32'h5678, 1'b1, 0);
        checks++;
        if (g_timeout || g_ill !== 1'b1 || g_write !== 1'b0 || g_lat != 1) begin
            failures++;
            $display("FAIL illegal got ill=%b write=%b lat=%0d to=%b exp ill=1 write=0 lat=1",
                     g_ill, g_write, g_lat, g_timeout);
        end
        checks++;
        if (g_s[0] !== g_pre_s || g_flags !== m_flags) begin
            failures++;
            $display("FAIL illegal_noexec got alu_s=%b flags=%b exp alu_s=%b flags=%b",
                     g_s[0], g_flags, g_pre_s, m_flags);
        end
    endtask

    task automatic test_backpressure;
        run_req(OP_ORR, 32'hA0, 32'h05, 1'b0, 3);
        checks++;
        if (g_stable !== 1'b1 || g_rdy_low !== 1'b1 || g_res !== 32'hA5) begin
            failures++;
            $display("FAIL backpressure got stable=%b rdy_low=%b res=%h exp 1 1 a5", g_stable, g_rdy_low, g_res);
        end
        checks++;
        if (g_rdy_after !== 1'b1) begin
            failures++; $display("FAIL ready_after_hs got=%b exp=1", g_rdy_after);
        end
    endtask

    task automatic test_random;
        exp_t e;
        logic [3:0] op;
        logic [31:0] a, b;
        logic s;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            s = 1'($urandom_range(0, 1));
            e = model(op, a, b, s, m_flags);
            run_req(op, a, b, s, $urandom_range(0, 2));
            checks++;
            if (g_timeout || g_ill !== e.ill || g_write !== e.write || g_lat != int'(e.lat) ||
                g_flags !== e.flags || (e.write && g_res !== e.res)) begin
                failures++;
                $display("FAIL random[%0d] op=%b a=%h b=%h s=%b got res=%h w=%b ill=%b lat=%0d fl=%b exp res=%h w=%b ill=%b lat=%0d fl=%b",
                         i, op, a, b, s, g_res, g_write, g_ill, g_lat, g_flags,
                         e.res, e.write, e.ill, e.lat, e.flags);
            end
            m_flags = e.flags;
        end
    endtask

    task automatic test_back_to_back;
        int n;
        bus.rsp_ready = 1'b1;
        bus.req_op = OP_ADD; bus.req_a = 32'd1; bus.req_b = 32'd2; bus.req_setflags = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.req_ready) n++;
        end
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++;
        if (n != 10) begin
            failures++; $display("FAIL throughput got accepts=%0d exp=10", n);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        e = model(OP_CMP, 32'd3, 32'd3, 1'b1, m_flags);
        run_req(OP_CMP, 32'd3, 32'd3, 1'b1, 0);
        m_flags = e.flags;
        bus.req_op = OP_BIC; bus.req_a = 32'hFF; bus.req_b = 32'h0F; bus.req_setflags = 1'b1;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.alu_s !== ALU_AND || bus.flags === 4'b0000) begin
            failures++; $display("FAIL pre_abort got alu_s=%b flags=%b exp alu_s=0101 flags!=0", bus.alu_s, bus.flags);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.flags !== 4'b0000 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort got valid=%b flags=%b ready=%b exp 0 0000 1", bus.rsp_valid, bus.flags, bus.req_ready);
        end
        m_flags = 4'b0000;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            failures++; $display("FAIL abort_no_rsp got valid=%b exp=0", bus.rsp_valid);
        end
        e = model(OP_SUB, 32'd1, 32'd2, 1'b1, m_flags);
        run_req(OP_SUB, 32'd1, 32'd2, 1'b1, 0);
        checks++;
        if (g_timeout || g_res !== e.res || g_flags !== e.flags) begin
            failures++;
            $display("FAIL after_abort got res=%h flags=%b exp res=%h flags=%b", g_res, g_flags, e.res, e.flags);
        end
        m_flags = e.flags;
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_op = 4'd0; bus.req_setflags = 1'b0;
        bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_cmp_mov();
        test_rsb();
        test_bic();
        test_illegal();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
